// File: rtl/bcd_pkg.sv
// Shared constants for the Excess-3 to BCD converter and its serial collector.
package bcd_pkg;

  localparam int NIBBLE_W = 4;
  localparam logic [NIBBLE_W-1:0] BCD_MAX = 4'd9;

  function automatic logic is_illegal(input logic [NIBBLE_W-1:0] n);
    return n > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_nibble_shifter.sv
// Rebuilds one LSB-first nibble from the serial stream, honouring gaps and reframing.
module bcd_nibble_shifter
  import bcd_pkg::*;
(
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Z_in,
  input  logic                In_valid,
  input  logic                Frame_start,
  output logic [NIBBLE_W-1:0] nibble,
  output logic                done
);

  logic [1:0] bit_idx;
  logic [2:0] shift;

  // done/nibble describe the digit being completed on this edge, so the
  // parent can register it without an extra cycle of latency.
  assign done   = In_valid && !Frame_start && (bit_idx == 2'd3);
  assign nibble = {Z_in, shift};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      bit_idx <= 2'd0;
      shift   <= 3'd0;
    end else if (In_valid) begin
      if (Frame_start) begin
        shift   <= {2'b00, Z_in};
        bit_idx <= 2'd1;
      end else begin
        case (bit_idx)
          2'd0:    shift[0] <= Z_in;
          2'd1:    shift[1] <= Z_in;
          2'd2:    shift[2] <= Z_in;
          default: ;
        endcase
        bit_idx <= bit_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_serial_collector.sv
// Packs completed BCD nibbles into NDIGITS-wide words and flags illegal digits.
module bcd_serial_collector
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        Z_in,
  input  logic                        In_valid,
  input  logic                        Frame_start,
  output logic [NIBBLE_W-1:0]         Digit,
  output logic                        Digit_valid,
  output logic                        Digit_err,
  output logic [NIBBLE_W*NDIGITS-1:0] Word,
  output logic                        Word_valid,
  output logic                        Word_err
);

  localparam int DIG_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(NDIGITS - 1);

  logic [NIBBLE_W-1:0] nibble;
  logic                done;
  logic                nib_err;
  logic [DIG_W-1:0]    dig_idx;
  logic                err_acc;

  bcd_nibble_shifter u_shifter (
    .Clk         (Clk),
    .Rst         (Rst),
    .Z_in        (Z_in),
    .In_valid    (In_valid),
    .Frame_start (Frame_start),
    .nibble      (nibble),
    .done        (done)
  );

  assign nib_err = is_illegal(nibble);

  // Illegal digits still occupy a word slot; only the error flag records them.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Digit       <= '0;
      Digit_valid <= 1'b0;
      Digit_err   <= 1'b0;
      Word        <= '0;
      Word_valid  <= 1'b0;
      Word_err    <= 1'b0;
      dig_idx     <= '0;
      err_acc     <= 1'b0;
    end else begin
      Digit_valid <= 1'b0;
      Digit_err   <= 1'b0;
      Word_valid  <= 1'b0;
      Word_err    <= 1'b0;
      if (done) begin
        Digit       <= nibble;
        Digit_valid <= 1'b1;
        Digit_err   <= nib_err;
        for (int i = 0; i < NDIGITS; i++) begin
          if (dig_idx == DIG_W'(i)) Word[NIBBLE_W*i +: NIBBLE_W] <= nibble;
        end
        if (dig_idx == LAST_DIG) begin
          Word_valid <= 1'b1;
          Word_err   <= err_acc | nib_err;
          err_acc    <= 1'b0;
          dig_idx    <= '0;
        end else begin
          err_acc <= err_acc | nib_err;
          dig_idx <= dig_idx + DIG_W'(1);
        end
      end
    end
  end

endmodule
